booth_div_reg: RTL and testbench

Sequential signed divider for the MACC datapath: the inverse of the registered radix-4 Booth multiplier. It takes a 15-bit signed product-width dividend and an 8-bit signed divisor, and returns an 8-bit quotient and 8-bit remainder. It computes one bit per cycle using restoring shift-subtract on magnitudes, followed by a sign-fix cycle. It is used for normalisation/rescaling of MAC results and as a round-trip check of the multiplier (product / operand = other operand).

---
 rtl/booth_div_reg_if.sv | 26 ++
 rtl/booth_div_reg.sv | 143 ++++++++++++++
 tb/tb_booth_div_reg.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/booth_div_reg_if.sv
// Handshake and operand/result bundle for the sequential signed divider.
// The slave modport faces the divider; the master modport faces its client.
interface booth_div_reg_if #(
  parameter int DW = 8,
  parameter int NW = 2*DW-1
);
  logic          i_start;
  logic [NW-1:0] i_dividend;
  logic [DW-1:0] i_divisor;
  logic          o_busy;
  logic          o_done;
  logic [DW-1:0] o_quot;
  logic [DW-1:0] o_rem;
  logic          o_dbz;
  logic          o_ovf;

  modport slave (
    input  i_start, i_dividend, i_divisor,
    output o_busy, o_done, o_quot, o_rem, o_dbz, o_ovf
  );

  modport master (
    output i_start, i_dividend, i_divisor,
    input  o_busy, o_done, o_quot, o_rem, o_dbz, o_ovf
  );
endinterface

// File: rtl/booth_div_reg.sv
// Sequential signed divider: NW-step restoring shift-subtract on magnitudes,
// then one sign-fix cycle with quotient saturation. All outputs are registered.
module booth_div_reg #(
  parameter int DW = 8,
  parameter int NW = 2*DW-1
) (
  input  logic            clk,
  input  logic            rst,
  booth_div_reg_if.slave  bus
);
  localparam int CW = $clog2(NW);
  localparam logic [NW-1:0] POS_LIM = NW'(2**(DW-1) - 1);
  localparam logic [NW-1:0] NEG_LIM = NW'(2**(DW-1));
  localparam logic [DW-1:0] Q_MAX   = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] Q_MIN   = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Dividend magnitude shifts out at the top while quotient bits enter at the bottom.
  logic [NW-1:0] dvd_q, dvd_d;
  logic [DW:0]   part_q, part_d;
  logic [DW-1:0] dsr_q, dsr_d;
  logic          sn_q, sn_d, sd_q, sd_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [DW-1:0] quot_q, quot_d, rem_q, rem_d;
  logic          dbz_q, dbz_d, ovf_q, ovf_d;

  logic [DW:0]   shifted;
  logic [DW:0]   diff;
  logic          qneg;
  logic          ovf_fix;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    part_d  = part_q;
    dsr_d   = dsr_q;
    sn_d    = sn_q;
    sd_d    = sd_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    shifted = {part_q[DW-1:0], dvd_q[NW-1]};
    diff    = shifted - {1'b0, dsr_q};
    qneg    = sn_q ^ sd_q;
    ovf_fix = qneg ? (dvd_q > NEG_LIM) : (dvd_q > POS_LIM);

    unique case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          if (bus.i_divisor == '0) begin
            quot_d = '0;
            rem_d  = '0;
            dbz_d  = 1'b1;
            ovf_d  = 1'b0;
            done_d = 1'b1;
          end else begin
            sn_d    = bus.i_dividend[NW-1];
            sd_d    = bus.i_divisor[DW-1];
            dvd_d   = bus.i_dividend[NW-1] ? ({NW{1'b0}} - bus.i_dividend) : bus.i_dividend;
            dsr_d   = bus.i_divisor[DW-1]  ? ({DW{1'b0}} - bus.i_divisor)  : bus.i_divisor;
            part_d  = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (shifted >= {1'b0, dsr_q}) begin
          part_d = diff;
          dvd_d  = {dvd_q[NW-2:0], 1'b1};
        end else begin
          part_d = shifted;
          dvd_d  = {dvd_q[NW-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NW-1)) state_d = FIX;
      end
      FIX: begin
        if (ovf_fix)   quot_d = qneg ? Q_MIN : Q_MAX;
        else if (qneg) quot_d = {DW{1'b0}} - dvd_q[DW-1:0];
        else           quot_d = dvd_q[DW-1:0];
        // The partial remainder is below |divisor| <= 128, so its low DW bits hold it exactly.
        rem_d   = sn_q ? ({DW{1'b0}} - part_q[DW-1:0]) : part_q[DW-1:0];
        ovf_d   = ovf_fix;
        dbz_d   = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: these are plain registers, not a memory array, so each one is reset to a known value.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      part_q  <= '0;
      dsr_q   <= '0;
      sn_q    <= 1'b0;
      sd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      part_q  <= part_d;
      dsr_q   <= dsr_d;
      sn_q    <= sn_d;
      sd_q    <= sd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;
  assign bus.o_quot = quot_q;
  assign bus.o_rem  = rem_q;
  assign bus.o_dbz  = dbz_q;
  assign bus.o_ovf  = ovf_q;
endmodule

// File: tb/tb_booth_div_reg.sv
// Self-checking bench for booth_div_reg: directed corner cases plus random
// operands scored against an integer-arithmetic reference model.
module tb_booth_div_reg;
  localparam int DW = 8;
  localparam int NW = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_div_reg_if #(.DW(DW), .NW(NW)) ifc ();

  booth_div_reg #(.DW(DW), .NW(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  typedef struct {
    int q;
    int r;
    int dbz;
    int ovf;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;
  int prev_q   = 0;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // SV integer division truncates toward zero and % takes the dividend's sign.
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q = 0; e.r = 0; e.dbz = 1; e.ovf = 0;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.dbz = 0;
      e.ovf = (e.q > 127 || e.q < -128) ? 1 : 0;
      if (e.q > 127)  e.q = 127;
      if (e.q < -128) e.q = -128;
    end
    return e;
  endfunction

  function automatic int outs_vec();
    return int'({ifc.o_busy, ifc.o_done, ifc.o_quot, ifc.o_rem, ifc.o_dbz, ifc.o_ovf});
  endfunction

  // Issue a start now (away from an edge), then follow the op to its o_done.
  // p1/p2 are post-accept cycle indices at which a stray start pulse is driven.
  task automatic run_op(input string tag, input int a, input int b, input int p1, input int p2);
    exp_t e;
    int   done_at;
    int   busy_cnt;
    int   both;
    e        = model(a, b);
    done_at  = -1;
    busy_cnt = 0;
    both     = 0;
    ifc.i_dividend = NW'(a);
    ifc.i_divisor  = DW'(b);
    ifc.i_start    = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      ifc.i_start = (k == p1 || k == p2);
      if (ifc.i_start) begin
        ifc.i_dividend = NW'($urandom);
        ifc.i_divisor  = DW'($urandom);
      end
      if (ifc.o_busy) busy_cnt++;
      if (ifc.o_busy && ifc.o_done) both++;
      if (k == 5 && b != 0) check({tag, "_hold_q"}, $signed(ifc.o_quot), prev_q);
      if (ifc.o_done) begin
        done_at = k;
        ifc.i_start = 1'b0;
        break;
      end
    end
    check({tag, "_done_edge"}, done_at, (b == 0) ? 0 : 16);
    check({tag, "_busy_cycles"}, busy_cnt, (b == 0) ? 0 : 16);
    check({tag, "_busy_and_done"}, both, 0);
    check({tag, "_quot"}, $signed(ifc.o_quot), e.q);
    check({tag, "_rem"}, $signed(ifc.o_rem), e.r);
    check({tag, "_dbz"}, int'(ifc.o_dbz), e.dbz);
    check({tag, "_ovf"}, int'(ifc.o_ovf), e.ovf);
    prev_q = e.q;
  endtask

  initial begin
    int          dones;
    logic [14:0] r15;
    logic [7:0]  r8;

    ifc.i_start    = 1'b0;
    ifc.i_dividend = '0;
    ifc.i_divisor  = '0;
    #3;
    check("reset_outputs", outs_vec(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("full_scale",  16129,  127,  -1, -1);
    run_op("neg7_2",         -7,    2,  -1, -1);
    run_op("100_neg7",      100,   -7,  -1, -1);
    run_op("neg1400_neg25",-1400,  -25,  -1, -1);
    run_op("zero_5",          0,    5,  -1, -1);
    run_op("ovf_pos",     16383,    1,  -1, -1);
    run_op("ovf_neg",    -16384,    1,  -1, -1);
    run_op("ovf_m128",   -16384, -128,  -1, -1);
    run_op("ovf_128",      -128,   -1,  -1, -1);
    run_op("dbz",          1234,    0,  -1, -1);
    run_op("after_dbz",      24,    3,  -1, -1);
    run_op("ignore_start",   56,    7,   3, 10);
    run_op("back_to_back",   15,   -4,  -1, -1);

    // Abort an op in flight with reset.
    ifc.i_dividend = NW'(100);
    ifc.i_divisor  = DW'(7);
    ifc.i_start    = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      ifc.i_start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("abort_outputs", outs_vec(), 0);
    dones = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (ifc.o_done) dones++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (ifc.o_done) dones++;
    end
    check("abort_no_done", dones, 0);
    prev_q = 0;
    @(negedge clk);
    run_op("after_abort", 127, 127, -1, -1);

    for (int i = 0; i < 60; i++) begin
      r15 = 15'($urandom);
      r8  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op($sformatf("rand%0d", i), int'($signed(r15)), int'($signed(r8)), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
